// File: rtl/piso_32bit_tx_pkg.sv
// Shared types and sizing for the parallel-in serial-out transmitter.
package piso_tx_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

endpackage

// File: rtl/piso_32bit_tx_hold_buf.sv
// One-entry holding buffer that lets a second word wait behind the shifter.
module piso_hold_buf
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (load) begin
                data_q <= din;
                full_q <= 1'b1;
            end else if (drain) begin
                full_q <= 1'b0;
            end
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule

// File: rtl/piso_32bit_tx.sv
// Word-to-bit transmitter feeding the downstream shift register's serial input.
module piso_32bit_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_nx;
    logic             ready_q;
    logic             accept;
    logic             last;
    logic             load;
    logic             drain;
    logic             full;
    logic [WIDTH-1:0] buf_q;

    assign accept = din_valid & ready_q;
    assign last   = (state_q == SHIFT) & (cnt_q == CNT_MAX);
    assign load   = accept & (state_q == SHIFT) & ~last;
    assign drain  = last & full;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shift_nx = {shift_q[WIDTH-2:0], 1'b0};
            assign so       = (state_q == SHIFT) & shift_q[WIDTH-1];
        end else begin : g_lsb
            assign shift_nx = {1'b0, shift_q[WIDTH-1:1]};
            assign so       = (state_q == SHIFT) & shift_q[0];
        end
    endgenerate

    piso_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .clear_n (clear_n),
        .load    (load),
        .drain   (drain),
        .din     (din),
        .dout    (buf_q),
        .full    (full)
    );

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            ready_q <= 1'b0;
        end else begin
            // Ready tracks whether the buffer will be empty after this edge.
            ready_q <= ~((full & ~drain) | load);
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q <= din;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        cnt_q <= '0;
                        if (full) begin
                            shift_q <= buf_q;
                        end else if (accept) begin
                            shift_q <= din;
                        end else begin
                            shift_q <= '0;
                            state_q <= IDLE;
                        end
                    end else begin
                        shift_q <= shift_nx;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign din_ready = ready_q;
    assign so_valid  = (state_q == SHIFT);
    assign so_last   = last;
    assign busy      = (state_q == SHIFT) | full;

endmodule

// File: tb/tb_piso_32bit_tx.sv
// Directed self-checking bench for piso_32bit_tx (MSB-first and LSB-first).
module tb_piso_32bit_tx;

    logic        clk = 1'b0;
    logic        clear_n;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        so;
    logic        so_valid;
    logic        so_last;
    logic        busy;

    logic [31:0] din_l;
    logic        din_valid_l;
    logic        din_ready_l;
    logic        so_l;
    logic        so_valid_l;
    logic        so_last_l;
    logic        busy_l;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] sbits;
    logic [63:0] lbits;
    int          vcnt;
    int          rdy2;
    int          rdy32;
    int          rdy33;
    int          rdy32b;

    always #5 clk = ~clk;

    piso_32bit_tx #(
        .WIDTH     (32),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .so        (so),
        .so_valid  (so_valid),
        .so_last   (so_last),
        .busy      (busy)
    );

    piso_32bit_tx #(
        .WIDTH     (32),
        .MSB_FIRST (1'b0)
    ) dut_l (
        .clk       (clk),
        .clear_n   (clear_n),
        .din       (din_l),
        .din_valid (din_valid_l),
        .din_ready (din_ready_l),
        .so        (so_l),
        .so_valid  (so_valid_l),
        .so_last   (so_last_l),
        .busy      (busy_l)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {so, so_valid, so_last, busy};
    endfunction

    initial begin
        clear_n     = 1'b0;
        din         = 32'hFFFF_FFFF;
        din_valid   = 1'b1;
        din_l       = 32'h0;
        din_valid_l = 1'b0;

        // reset held for three edges with a word offered
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_outs", 64'(outs()), 64'h0);
            check("rst_ready", 64'(din_ready), 64'h0);
        end
        din_valid = 1'b0;
        clear_n   = 1'b1;
        step();
        check("rel_ready", 64'(din_ready), 64'h1);
        check("rel_busy", 64'(busy), 64'h0);

        // single word, MSB first
        din       = 32'hA500_0001;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        sbits = '0;
        lbits = '0;
        vcnt  = 0;
        for (int k = 1; k <= 32; k++) begin
            sbits[32-k] = so;
            lbits[k-1]  = so_last;
            vcnt += int'(so_valid);
            step();
        end
        check("single_data", sbits & 64'hFFFF_FFFF, 64'hA500_0001);
        check("single_last", lbits, 64'h8000_0000);
        check("single_vcnt", 64'(vcnt), 64'd32);
        check("single_idle", 64'({so_valid, busy}), 64'h0);

        // back-to-back with din_valid held high
        din       = 32'hFFFF_0000;
        din_valid = 1'b1;
        step();
        din   = 32'h0000_FFFF;
        sbits = '0;
        lbits = '0;
        vcnt  = 0;
        for (int k = 1; k <= 64; k++) begin
            sbits[64-k] = so;
            lbits[k-1]  = so_last;
            vcnt += int'(so_valid);
            if (k == 2)  rdy2  = int'(din_ready);
            if (k == 32) rdy32 = int'(din_ready);
            if (k == 33) rdy33 = int'(din_ready);
            if (k == 2)  din_valid = 1'b0;
            step();
        end
        check("b2b_data", sbits, 64'hFFFF_0000_0000_FFFF);
        check("b2b_last", lbits, 64'h8000_0000_8000_0000);
        check("b2b_vcnt", 64'(vcnt), 64'd64);
        check("b2b_rdy2", 64'(rdy2), 64'h0);
        check("b2b_rdy32", 64'(rdy32), 64'h0);
        check("b2b_rdy33", 64'(rdy33), 64'h1);
        check("b2b_idle", 64'(so_valid), 64'h0);

        // bypass: second word offered only in the last-bit cycle
        din       = 32'h8000_0001;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        sbits = '0;
        lbits = '0;
        vcnt  = 0;
        for (int k = 1; k <= 64; k++) begin
            sbits[64-k] = so;
            lbits[k-1]  = so_last;
            vcnt += int'(so_valid);
            if (k == 32) begin
                rdy32b    = int'(din_ready);
                din       = 32'hC000_0000;
                din_valid = 1'b1;
            end
            if (k == 33) din_valid = 1'b0;
            step();
        end
        check("byp_data", sbits, 64'h8000_0001_C000_0000);
        check("byp_last", lbits, 64'h8000_0000_8000_0000);
        check("byp_vcnt", 64'(vcnt), 64'd64);
        check("byp_rdy", 64'(rdy32b), 64'h1);
        check("byp_idle", 64'({so_valid, busy}), 64'h0);

        // LSB-first instance
        din_l       = 32'h0000_0003;
        din_valid_l = 1'b1;
        step();
        din_valid_l = 1'b0;
        sbits = '0;
        lbits = '0;
        vcnt  = 0;
        for (int k = 1; k <= 32; k++) begin
            sbits[k-1] = so_l;
            lbits[k-1] = so_last_l;
            vcnt += int'(so_valid_l);
            step();
        end
        check("lsb_data", sbits, 64'h0000_0003);
        check("lsb_last", lbits, 64'h8000_0000);
        check("lsb_vcnt", 64'(vcnt), 64'd32);
        check("lsb_idle", 64'({so_valid_l, busy_l}), 64'h0);

        // reset mid-word with the buffer full
        din       = 32'hFFFF_FFFF;
        din_valid = 1'b1;
        step();
        din = 32'hFFFF_FFFF;
        step();
        din_valid = 1'b0;
        check("mid_buf_full", 64'({busy, din_ready}), 64'h2);
        for (int k = 2; k < 10; k++) step();
        check("mid_so_before", 64'({so, so_valid}), 64'h3);
        clear_n = 1'b0;
        step();
        check("mid_rst_outs", 64'(outs()), 64'h0);
        check("mid_rst_ready", 64'(din_ready), 64'h0);
        clear_n = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            vcnt += int'(so_valid) + int'(busy);
        end
        check("mid_no_resume", 64'(vcnt), 64'd0);
        check("mid_ready", 64'(din_ready), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
